// File: rtl/interrupt_scheduler_if.sv
// Source-side and processor-side interrupt handshakes plus the bus address/strobe.
// The tri-state data line is a plain port on the scheduler.
interface interrupt_scheduler_if #(
    parameter int unsigned NUM_SRC = 4
);
    logic [NUM_SRC-1:0] src_raise;
    logic [NUM_SRC-1:0] src_ack;
    logic [NUM_SRC-1:0] cpu_raise;
    logic [NUM_SRC-1:0] cpu_ack;
    logic [7:0]         bus_addr;
    logic               bus_we;

    modport master (
        output src_raise, cpu_ack, bus_addr, bus_we,
        input  src_ack, cpu_raise
    );

    modport slave (
        input  src_raise, cpu_ack, bus_addr, bus_we,
        output src_ack, cpu_raise
    );
endinterface

// File: rtl/interrupt_scheduler.sv
// Captures interrupt raise edges as pending bits and grants one source at a time to the CPU,
// with fixed or round-robin priority and a bus-mapped mask/pend/clear/ctrl register file.
module interrupt_scheduler #(
    parameter int unsigned NUM_SRC   = 4,
    parameter logic [7:0]  BASE_ADDR = 8'hE0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    interrupt_scheduler_if.slave irq,
    inout  wire  [7:0]           bus_data
);
    localparam int unsigned IdxW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] prev_raise_q;
    logic [NUM_SRC-1:0] cpu_raise_q, cpu_raise_d;
    logic [NUM_SRC-1:0] src_ack_q, src_ack_d;
    logic               mode_q, mode_d;
    logic [3:0]         drops_q, drops_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]    win_q, win_d;
    logic [7:0]         wait_q, wait_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_oe_q;

    logic [NUM_SRC-1:0] rise, elig;
    logic [IdxW-1:0]    cand, pick;
    logic               pick_valid;
    logic [7:0]         offset;
    logic               addr_hit, rd_en, wr_mask, wr_clear, wr_ctrl;
    logic               unused_data;

    function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
        return (i == IdxW'(NUM_SRC - 1)) ? '0 : i + 1'b1;
    endfunction

    assign rise     = irq.src_raise & ~prev_raise_q;
    assign elig     = pend_q & mask_q;
    assign offset   = irq.bus_addr - BASE_ADDR;
    assign addr_hit = offset < 8'd4;
    assign rd_en    = !irq.bus_we && addr_hit;
    assign wr_mask  = irq.bus_we && addr_hit && (offset[1:0] == 2'd0);
    assign wr_clear = irq.bus_we && addr_hit && (offset[1:0] == 2'd2);
    assign wr_ctrl  = irq.bus_we && addr_hit && (offset[1:0] == 2'd3);

    assign unused_data = ^bus_data;

    assign bus_data      = rd_oe_q ? rd_data_q : 8'hzz;
    assign irq.cpu_raise = cpu_raise_q;
    assign irq.src_ack   = src_ack_q;

    // Scan starts at the RR pointer in round-robin mode, at index 0 in fixed mode.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = mode_q ? rr_ptr_q : '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!pick_valid && elig[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
            cand = inc_idx(cand);
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        wait_d      = wait_q;
        rr_ptr_d    = rr_ptr_q;
        drops_d     = drops_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        pend_d      = pend_q;
        cpu_raise_d = '0;
        src_ack_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StGrant;
                    win_d   = pick;
                    wait_d  = '0;
                end
            end
            StGrant: begin
                if (irq.cpu_ack[win_q]) begin
                    state_d          = StAck;
                    src_ack_d[win_q] = 1'b1;
                end else if (wait_q == 8'(TIMEOUT - 1)) begin
                    state_d  = StIdle;
                    rr_ptr_d = inc_idx(win_q);
                    if (drops_q != 4'hF) drops_d = drops_q + 4'd1;
                end else begin
                    wait_d             = wait_q + 8'd1;
                    cpu_raise_d[win_q] = 1'b1;
                end
            end
            StAck: begin
                state_d       = StIdle;
                pend_d[win_q] = 1'b0;
                rr_ptr_d      = inc_idx(win_q);
            end
            default: state_d = StIdle;
        endcase

        if (wr_mask) mask_d = bus_data[NUM_SRC-1:0];
        if (wr_clear) pend_d = pend_d & ~bus_data[NUM_SRC-1:0];
        if (wr_ctrl) begin
            mode_d  = bus_data[0];
            drops_d = '0;
        end
        // New edges are merged last so a same-cycle set beats any clear.
        pend_d = pend_d | rise;
    end

    always_comb begin
        rd_data_d = '0;
        unique case (offset[1:0])
            2'd0:    rd_data_d = 8'(mask_q);
            2'd1:    rd_data_d = 8'(pend_q);
            2'd2:    rd_data_d = '0;
            default: rd_data_d = {drops_q, 3'b000, mode_q};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mask_q       <= '1;
            pend_q       <= '0;
            prev_raise_q <= '0;
            mode_q       <= 1'b0;
            drops_q      <= '0;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            wait_q       <= '0;
            cpu_raise_q  <= '0;
            src_ack_q    <= '0;
            rd_data_q    <= '0;
            rd_oe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            prev_raise_q <= irq.src_raise;
            mode_q       <= mode_d;
            drops_q      <= drops_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            wait_q       <= wait_d;
            cpu_raise_q  <= cpu_raise_d;
            src_ack_q    <= src_ack_d;
            rd_data_q    <= rd_data_d;
            rd_oe_q      <= rd_en;
        end
    end
endmodule

// File: tb/tb_interrupt_scheduler.sv
// Directed bench for interrupt_scheduler: latency, fixed/RR arbitration, masking, clear,
// timeout with drop counter, and asynchronous reset during a grant.
module tb_interrupt_scheduler;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned TIMEOUT = 4;

    logic       clk;
    logic       rst_n;
    logic       tb_oe;
    logic [7:0] tb_data;
    wire  [7:0] bus_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] rr_exp [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

    interrupt_scheduler_if #(.NUM_SRC(NUM_SRC)) irq ();

    interrupt_scheduler #(
        .NUM_SRC  (NUM_SRC),
        .BASE_ADDR(8'hE0),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq     (irq),
        .bus_data(bus_data)
    );

    assign bus_data = tb_oe ? tb_data : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        irq.src_raise = '0;
        irq.cpu_ack   = '0;
        irq.bus_addr  = 8'h00;
        irq.bus_we    = 1'b0;
        tb_oe         = 1'b0;
        tb_data       = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns one idle cycle after the data sample.
    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        irq.bus_addr = addr;
        irq.bus_we   = 1'b0;
        @(negedge clk);
        data         = bus_data;
        irq.bus_addr = 8'h00;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        irq.bus_addr = addr;
        irq.bus_we   = 1'b1;
        tb_data      = data;
        tb_oe        = 1'b1;
        @(negedge clk);
        irq.bus_we   = 1'b0;
        irq.bus_addr = 8'h00;
        tb_oe        = 1'b0;
    endtask

    task automatic wait_raise(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (irq.cpu_raise == 4'h0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, irq.cpu_raise, exp);
    endtask

    task automatic count_raise(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (irq.cpu_raise != 4'h0) hits++;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [3:0] got;
        logic       seen_ack;
        logic       bus_idle;
        int         n;

        do_reset();
        check("rst_cpu_raise", irq.cpu_raise, 4'h0);
        check("rst_src_ack", irq.src_ack, 4'h0);
        bus_read(8'hE0, rd); check("rst_mask", rd, 8'h0F);
        bus_read(8'hE1, rd); check("rst_pend", rd, 8'h00);
        bus_read(8'hE3, rd); check("rst_ctrl", rd, 8'h00);

        // Single pulse on source 1: exact 3-cycle latency and ack return.
        irq.src_raise = 4'h2;
        @(negedge clk);
        irq.src_raise = 4'h0;
        irq.bus_addr  = 8'hE1;
        check("lat_c1", irq.cpu_raise, 4'h0);
        @(negedge clk);
        check("pulse_pend", bus_data, 8'h02);
        check("lat_c2", irq.cpu_raise, 4'h0);
        irq.bus_addr = 8'h00;
        @(negedge clk);
        check("lat_c3", irq.cpu_raise, 4'h2);
        irq.cpu_ack = 4'h2;
        @(negedge clk);
        irq.cpu_ack = 4'h0;
        check("pulse_src_ack", irq.src_ack, 4'h2);
        check("pulse_raise_drop", irq.cpu_raise, 4'h0);
        @(negedge clk);
        check("pulse_src_ack_once", irq.src_ack, 4'h0);
        bus_read(8'hE1, rd); check("pulse_pend_clr", rd, 8'h00);

        // Fixed priority with sources 0 and 2; source 0 held high throughout.
        irq.src_raise = 4'h5;
        @(negedge clk);
        irq.src_raise = 4'h1;
        wait_raise("fix_first", 4'h1);
        irq.cpu_ack = 4'h1;
        @(negedge clk);
        irq.cpu_ack = 4'h0;
        check("fix_ack0", irq.src_ack, 4'h1);
        @(negedge clk);
        check("fix_idle_gap", irq.cpu_raise, 4'h0);
        @(negedge clk);
        check("fix_grant_entry", irq.cpu_raise, 4'h0);
        @(negedge clk);
        check("fix_second", irq.cpu_raise, 4'h4);
        irq.cpu_ack = 4'h4;
        @(negedge clk);
        irq.cpu_ack = 4'h0;
        check("fix_ack2", irq.src_ack, 4'h4);
        count_raise(6, n);
        check("fix_held_level_once", n, 0);
        irq.src_raise = 4'h0;
        bus_read(8'hE1, rd); check("fix_pend_empty", rd, 8'h00);

        // Round-robin with every acked source re-raising during its ack cycle.
        do_reset();
        bus_write(8'hE3, 8'h01);
        irq.src_raise = 4'hF;
        @(negedge clk);
        irq.src_raise = 4'h0;
        for (int i = 0; i < 5; i++) begin
            wait_raise($sformatf("rr_grant%0d", i), rr_exp[i]);
            got         = irq.cpu_raise;
            irq.cpu_ack = got;
            @(negedge clk);
            irq.cpu_ack   = 4'h0;
            irq.src_raise = got;
            @(negedge clk);
            irq.src_raise = 4'h0;
        end

        // Masking and clear.
        do_reset();
        bus_write(8'hE0, 8'h0B);
        bus_read(8'hE0, rd); check("mask_readback", rd, 8'h0B);
        irq.src_raise = 4'h4;
        @(negedge clk);
        irq.src_raise = 4'h0;
        count_raise(6, n);
        check("mask_blocks", n, 0);
        bus_read(8'hE1, rd); check("mask_pend_kept", rd, 8'h04);
        bus_write(8'hE1, 8'h00);
        bus_read(8'hE1, rd); check("pend_ro", rd, 8'h04);
        bus_write(8'hE0, 8'h0F);
        wait_raise("mask_unmask_grant", 4'h4);
        irq.cpu_ack = 4'h4;
        @(negedge clk);
        irq.cpu_ack = 4'h0;
        @(negedge clk);
        bus_write(8'hE0, 8'h0B);
        irq.src_raise = 4'h4;
        @(negedge clk);
        irq.src_raise = 4'h0;
        @(negedge clk);
        bus_write(8'hE2, 8'h04);
        bus_read(8'hE1, rd); check("clear_pend", rd, 8'h00);
        bus_read(8'hE2, rd); check("clear_reads0", rd, 8'h00);
        bus_write(8'hE0, 8'h0F);
        count_raise(6, n);
        check("clear_no_grant", n, 0);

        // Timeout on source 3 with a wrong-bit ack present.
        irq.src_raise = 4'h8;
        @(negedge clk);
        irq.src_raise = 4'h0;
        wait_raise("to_grant", 4'h8);
        irq.cpu_ack = 4'h1;
        n           = 0;
        seen_ack    = 1'b0;
        while (irq.cpu_raise == 4'h8 && n < 20) begin
            n++;
            @(negedge clk);
            if (irq.src_ack != 4'h0) seen_ack = 1'b1;
        end
        irq.cpu_ack = 4'h0;
        check("to_raise_cycles", n, TIMEOUT - 1);
        check("to_wrong_ack_ignored", seen_ack, 1'b0);
        check("to_withdrawn", irq.cpu_raise, 4'h0);
        irq.bus_addr = 8'hE3;
        @(negedge clk);
        check("to_drops", bus_data, 8'h10);
        irq.bus_addr = 8'h00;
        wait_raise("to_regrant", 4'h8);
        irq.cpu_ack = 4'h8;
        @(negedge clk);
        irq.cpu_ack = 4'h0;
        check("to_late_ack", irq.src_ack, 4'h8);
        @(negedge clk);
        bus_read(8'hE1, rd); check("to_pend_clr", rd, 8'h00);
        bus_write(8'hE3, 8'h00);
        bus_read(8'hE3, rd); check("to_drops_zeroed", rd, 8'h00);

        // Asynchronous reset while granted, with a read in its drive cycle.
        irq.src_raise = 4'h2;
        @(negedge clk);
        irq.src_raise = 4'h0;
        wait_raise("ar_grant", 4'h2);
        irq.bus_addr = 8'hE0;
        @(negedge clk);
        irq.bus_addr = 8'h00;
        check("ar_read_drives", bus_data, 8'h0F);
        rst_n = 1'b0;
        #1;
        check("ar_raise_async", irq.cpu_raise, 4'h0);
        bus_idle = (bus_data === 8'hzz) || (bus_data === 8'h00);
        check("ar_bus_released", bus_idle, 1'b1);
        repeat (2) @(negedge clk);
        check("ar_src_ack", irq.src_ack, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(8'hE1, rd); check("ar_pend", rd, 8'h00);
        count_raise(4, n);
        check("ar_no_regrant", n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
